// File: rtl/muldiv_unit.sv
// muldiv_unit: shared multi-cycle RV32M multiply/divide unit with pipeline stall and slot-tagged registered result.
// Ports: clk, rst (sync active-high), flush (abort in-flight op), m_AluOp/m_s1/m_s2/m_prio (request and slot tag),
//        md_stall (pipeline hold), md_busy (state != IDLE), md_done (1-cycle result pulse), md_result, md_slot.
// Optional: define MULDIV_EARLY_OUT_EN to finish divides with |dividend| < |divisor| in one cycle.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif
`ifndef ALU_MUL
`define ALU_MUL 5'd16
`endif
`ifndef ALU_REMU
`define ALU_REMU 5'd23
`endif
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [`ALU_OP_WIDTH-1:0] m_AluOp,
  input  logic [DATA_WIDTH-1:0]    m_s1,
  input  logic [DATA_WIDTH-1:0]    m_s2,
  input  logic [1:0]               m_prio,
  output logic                     md_stall,
  output logic                     md_busy,
  output logic                     md_done,
  output logic [DATA_WIDTH-1:0]    md_result,
  output logic                     md_slot
);
  localparam int W = DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [2:0] rel, op;
  logic [W-1:0] a, b, quo, rem, dvs, abs1, abs2, fast_q, fast_r, rem_n, q_fin, r_fin;
  logic [CNT_WIDTH-1:0] cnt;
  logic last, neg_q, neg_r, req, is_div, dsgn, div0, ovf, early, fast, ge, sa, sb;
  logic [W:0] shl;
  logic [2*W-1:0] ma, mb, prod;
  // op offset within the M group: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
  assign rel = 3'(m_AluOp - `ALU_MUL);
  assign req = m_prio[1] & (m_AluOp >= `ALU_MUL) & (m_AluOp <= `ALU_REMU) & ~flush;
  assign is_div = rel[2];
  assign dsgn = ~rel[0];
  assign abs1 = (dsgn & m_s1[W-1]) ? -m_s1 : m_s1;
  assign abs2 = (dsgn & m_s2[W-1]) ? -m_s2 : m_s2;
  assign div0 = m_s2 == '0;
  assign ovf = dsgn & (m_s1 == {1'b1, {(W-1){1'b0}}}) & (&m_s2);
`ifdef MULDIV_EARLY_OUT_EN
  assign early = abs1 < abs2;
`else
  assign early = 1'b0;
`endif
  assign fast = is_div & (div0 | ovf | early);
  assign fast_q = div0 ? '1 : ovf ? m_s1 : '0;
  assign fast_r = div0 ? m_s1 : ovf ? '0 : m_s1;
  // Sign-extending to 2W keeps the low 2W product bits exact for all signedness mixes
  assign sa = (op == 3'd1 || op == 3'd2) & a[W-1];
  assign sb = (op == 3'd1) & b[W-1];
  assign ma = {{W{sa}}, a};
  assign mb = {{W{sb}}, b};
  assign prod = ma * mb;
  assign shl = {rem, quo[W-1]};
  assign ge = shl >= {1'b0, dvs};
  assign rem_n = ge ? W'(shl - {1'b0, dvs}) : shl[W-1:0];
  assign q_fin = neg_q ? -quo : quo;
  assign r_fin = neg_r ? -rem : rem;
  assign md_stall = ((state == IDLE) & req) | (state == MUL) | (state == DIV);
  assign md_busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      md_done <= 1'b0;
      md_result <= '0;
      md_slot <= 1'b0;
      cnt <= '0;
      last <= 1'b0;
      op <= '0;
      a <= '0;
      b <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        IDLE: if (req) begin
          md_slot <= m_prio[0];
          op <= rel;
          a <= m_s1;
          b <= m_s2;
          quo <= abs1;
          dvs <= abs2;
          rem <= '0;
          cnt <= CNT_WIDTH'(W - 1);
          last <= 1'b0;
          neg_q <= dsgn & (m_s1[W-1] ^ m_s2[W-1]);
          neg_r <= dsgn & m_s1[W-1];
          if (fast) begin
            md_result <= rel[1] ? fast_r : fast_q;
            md_done <= 1'b1;
            state <= DONE;
          end else state <= is_div ? DIV : MUL;
        end
        MUL: if (flush) state <= IDLE;
        else begin
          md_result <= (op == 3'd0) ? prod[W-1:0] : prod[2*W-1:W];
          md_done <= 1'b1;
          state <= DONE;
        end
        // After the last quotient bit, one extra cycle applies the sign fix-up
        DIV: if (flush) state <= IDLE;
        else if (last) begin
          md_result <= op[1] ? r_fin : q_fin;
          md_done <= 1'b1;
          state <= DONE;
        end else begin
          rem <= rem_n;
          quo <= {quo[W-2:0], ge};
          cnt <= cnt - 1'b1;
          last <= cnt == '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed RV32M vectors.
`ifndef ALU_MUL
`define ALU_MUL 5'd16
`endif
module tb_muldiv_unit;
  localparam logic [4:0] OP_MUL = `ALU_MUL, OP_MULH = `ALU_MUL + 5'd1, OP_MULHSU = `ALU_MUL + 5'd2,
    OP_MULHU = `ALU_MUL + 5'd3, OP_DIV = `ALU_MUL + 5'd4, OP_DIVU = `ALU_MUL + 5'd5,
    OP_REM = `ALU_MUL + 5'd6, OP_REMU = `ALU_MUL + 5'd7;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO = 1;
`else
  localparam int EO = 34;
`endif
  typedef struct {
    logic [31:0] res;
    logic slot;
    int cy;
  } exp_t;
  logic clk = 0, rst = 1, flush = 0;
  logic [4:0] m_AluOp = '0;
  logic [31:0] m_s1 = '0, m_s2 = '0;
  logic [1:0] m_prio = '0;
  logic md_stall, md_busy, md_done, md_slot;
  logic [31:0] md_result;
  exp_t sb[$];
  int cyc = 0, total = 0, bad = 0;
  muldiv_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .m_AluOp(m_AluOp), .m_s1(m_s1), .m_s2(m_s2),
    .m_prio(m_prio), .md_stall(md_stall), .md_busy(md_busy), .md_done(md_done),
    .md_result(md_result), .md_slot(md_slot)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, got, want, cyc);
    end
  endtask
  // Monitor: every md_done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && md_done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", md_result, e.res);
        chk("slot", {31'd0, md_slot}, {31'd0, e.slot});
        chk("done_cycle", cyc, e.cy);
      end
    end
  end
  // Presents one request at cycle T, holds it while md_stall=1, and checks the stall length
  task automatic issue(input logic [4:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic slot, input logic [31:0] want, input int lat, input logic fl_done);
    int st, n;
    @(negedge clk);
    m_AluOp = op; m_s1 = s1; m_s2 = s2; m_prio = {1'b1, slot};
    sb.push_back('{want, slot, cyc + lat});
    st = 0; n = 0;
    #1;
    while (md_stall && n < 200) begin
      st++; n++;
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", st, lat);
    m_prio = 2'b00;
    if (fl_done) begin
      flush = 1;
      @(posedge clk);
      #1 flush = 0;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_stall", {31'd0, md_stall}, 32'd0);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_done", {31'd0, md_done}, 32'd0);
    chk("rst_result", md_result, 32'd0);
    chk("rst_slot", {31'd0, md_slot}, 32'd0);
    issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFEB, 2, 0);
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 2, 0);
    issue(OP_MULHSU, 32'hFFFFFFFF, 32'd2, 1'b0, 32'hFFFFFFFF, 2, 0);
    issue(OP_MULH, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 2, 0);
    issue(OP_DIV, 32'hFFFFFFEC, 32'd3, 1'b0, 32'hFFFFFFFA, 34, 0);
    issue(OP_REM, 32'hFFFFFFEC, 32'd3, 1'b1, 32'hFFFFFFFE, 34, 0);
    issue(OP_DIV, 32'd20, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFA, 34, 0);
    issue(OP_REM, 32'd20, 32'hFFFFFFFD, 1'b0, 32'd2, 34, 0);
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 34, 0);
    issue(OP_REMU, 32'd100, 32'd7, 1'b0, 32'd2, 34, 0);
    issue(OP_DIVU, 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 1, 0);
    issue(OP_REMU, 32'd5, 32'd0, 1'b1, 32'd5, 1, 0);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1, 0);
    issue(OP_REM, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 1, 0);
    issue(OP_DIVU, 32'd3, 32'd10, 1'b0, 32'd0, EO, 0);
    issue(OP_REMU, 32'd3, 32'd10, 1'b1, 32'd3, EO, 0);
    // flush during DONE must not suppress the pulse
    issue(OP_MUL, 32'd6, 32'd7, 1'b0, 32'd42, 2, 1);
    // flush mid-divide
    @(negedge clk);
    m_AluOp = OP_DIVU; m_s1 = 32'd100; m_s2 = 32'd7; m_prio = 2'b10;
    repeat (10) @(negedge clk);
    flush = 1; m_prio = 2'b00;
    @(negedge clk);
    flush = 0;
    #1;
    chk("flush_busy", {31'd0, md_busy}, 32'd0);
    chk("flush_done", {31'd0, md_done}, 32'd0);
    chk("flush_result_held", md_result, 32'd42);
    issue(OP_MUL, 32'd3, 32'd4, 1'b1, 32'd12, 2, 0);
    // reset mid-divide
    @(negedge clk);
    m_AluOp = OP_DIVU; m_s1 = 32'd100; m_s2 = 32'd7; m_prio = 2'b11;
    repeat (10) @(negedge clk);
    rst = 1; m_prio = 2'b00;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst2_busy", {31'd0, md_busy}, 32'd0);
    chk("rst2_done", {31'd0, md_done}, 32'd0);
    chk("rst2_stall", {31'd0, md_stall}, 32'd0);
    chk("rst2_result", md_result, 32'd0);
    chk("rst2_slot", {31'd0, md_slot}, 32'd0);
    issue(OP_MUL, 32'd3, 32'd4, 1'b0, 32'd12, 2, 0);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Shared multi-cycle multiply/divide unit in the execute stage, downstream of the dual-issue instruction-ordering logic. It consumes the single M-extension request that the ordering logic selects from issue slot 0 or slot 1 (op, operands, priority tag). It stalls the pipeline while working and returns a registered result tagged with the originating slot. It covers the RV32M ops MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, decoded by the `ALU_MUL..`ALU_REMU macros in Define.v.

Parameters:
DATA_WIDTH, 32, operand/result width.
CNT_WIDTH, 6, divide iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  pipeline flush (branch mispredict or trap); aborts any operation.
m_AluOp  in  `ALU_OP_WIDTH  selected M-extension op; held stable by the pipeline while md_stall=1.
m_s1  in  DATA_WIDTH  rs1 operand (multiplicand / dividend).
m_s2  in  DATA_WIDTH  rs2 operand (multiplier / divisor).
m_prio  in  2  request tag: 2'b10 = slot 0, 2'b11 = slot 1, 2'b0x = no request.
md_stall  out  1  pipeline hold request.
md_busy  out  1  unit is occupied (state != IDLE).
md_done  out  1  one-cycle result-valid pulse.
md_result  out  DATA_WIDTH  result; valid while md_done=1 and held afterwards.
md_slot  out  1  originating slot (captured m_prio[0]).

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, md_done=0, md_busy=0, md_stall=0, md_result=0, md_slot=0, counter=0. Reset mid-operation discards all work; no md_done is produced.
- req = m_prio[1] & (m_AluOp within `ALU_MUL..`ALU_REMU) & ~flush.
- States:
  - IDLE: on req, capture operands/op/slot and go to MUL, DIV or DONE (fast path).
  - MUL: one cycle, then DONE.
  - DIV: DATA_WIDTH iterations, then DONE.
  - DONE: asserts md_done for one cycle, then IDLE.
- md_stall = (IDLE & req) | MUL | DIV. It is 0 in DONE, so the pipeline advances in the same cycle md_done=1. The held request is not re-accepted because DONE always returns to IDLE.
- Latency from accept cycle T:
  - MUL family: md_done at T+2 (one stall cycle after accept).
  - DIV family: md_done at T+DATA_WIDTH+2.
  - Fast path: md_done at T+1.
- Multiply:
  - Sign/zero-extend operands to DATA_WIDTH+1 bits: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned.
  - Form the 2*DATA_WIDTH product. MUL returns the low half; the others return the high half.
- Divide:
  - Radix-2 restoring on magnitudes: one quotient bit per cycle, counter counts DATA_WIDTH-1 down to 0.
  - Signed ops: quotient is negated if operand signs differ; remainder takes the dividend's sign. REM/REMU return the remainder, DIV/DIVU the quotient.
- Fast path (always present), goes IDLE→DONE:
  - Divisor == 0: quotient = all ones, remainder = dividend.
  - Signed overflow (dividend = 0x80000000, divisor = -1): quotient = 0x80000000, remainder = 0.
- flush has priority over everything except rst:
  - In MUL or DIV: go to IDLE next cycle, no md_done, md_result unchanged.
  - In DONE: md_done still pulses, because the result belongs to an already-committed cycle.
- A request arriving while busy is not accepted; it stays held by md_stall.
- md_busy = (state != IDLE).

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: for DIV-family ops with nonzero divisor and |dividend| < |divisor| (unsigned compare of magnitudes), take the fast path: quotient = 0, remainder = dividend; md_done at T+1.
- Undefined: these cases run the full DATA_WIDTH iterations and give identical results.

Test Plan:
- MUL, m_s1=7, m_s2=0xFFFFFFFD, m_prio=2'b11 at T → md_stall=1 at T, md_done=1 at T+2 with md_result=0xFFFFFFEB and md_slot=1.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF. MULH 0x80000000×0x80000000 → 0x40000000.
- DIV −20/3 → 0xFFFFFFFA; REM −20/3 → 0xFFFFFFFE; md_done exactly at T+34 and md_stall high T..T+33.
- DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM of the same → 0; each md_done at T+1.
- Start DIVU; assert flush at T+10 → no md_done, md_busy=0 at T+11. Then accept MUL 3×4 → 12 at done. Repeat the sequence with rst instead of flush: all outputs return to reset values.
- DIVU 3/10 → 0 and REMU 3/10 → 3: md_done at T+1 with MULDIV_EARLY_OUT_EN, T+34 without.
